fight_arbiter: RTL and testbench

FIGHT_ARBITER -- requirements
Module: fight_arbiter

---
 rtl/fight_arbiter_if.sv | 26 ++
 rtl/fight_arbiter.sv | 157 +++++++++++++++
 tb/tb_fight_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fight_arbiter_if.sv
// Bus between the game logic and the fight arbiter.
// The master drives per-frame player inputs; the slave returns hits, health and round status.
interface fight_arbiter_if;
    logic       frame_tick;
    logic       p1_punch;
    logic       p2_punch;
    logic [9:0] p1_x;
    logic [9:0] p2_x;
    logic       restart;
    logic       p1_hit;
    logic       p2_hit;
    logic [7:0] p1_health;
    logic [7:0] p2_health;
    logic       round_over;
    logic [1:0] winner;

    modport master (
        output frame_tick, p1_punch, p2_punch, p1_x, p2_x, restart,
        input  p1_hit, p2_hit, p1_health, p2_health, round_over, winner
    );

    modport slave (
        input  frame_tick, p1_punch, p2_punch, p1_x, p2_x, restart,
        output p1_hit, p2_hit, p1_health, p2_health, round_over, winner
    );
endinterface

// File: rtl/fight_arbiter.sv
// Two-player punch arbiter: range check, damage, hitstop freeze and KO/restart handling.
// All game decisions are taken on frame_tick cycles; landed flags clear on any cycle.
module fight_arbiter #(
    parameter logic [9:0] REACH          = 10'd48,
    parameter logic [7:0] DAMAGE         = 8'd10,
    parameter logic [7:0] MAX_HEALTH     = 8'd100,
    parameter logic [3:0] HITSTOP_FRAMES = 4'd6
) (
    input logic          clk,
    input logic          rst_n,
    fight_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        FIGHT   = 2'd0,
        HITSTOP = 2'd1,
        KO      = 2'd2
    } state_t;

    localparam logic [3:0] HITSTOP_LOAD = (HITSTOP_FRAMES == 4'd0) ? 4'd1 : HITSTOP_FRAMES;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        sat_sub = (a > b) ? (a - b) : 8'd0;
    endfunction

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       p1_landed_r;
    logic       p2_landed_r;
    logic       p1_hit_r;
    logic       p2_hit_r;
    logic [7:0] p1_health_r;
    logic [7:0] p2_health_r;
    logic       round_over_r;
    logic [1:0] winner_r;

    logic [9:0] dist_s;
    logic       in_range_s;
    logic       p1_land_s;
    logic       p2_land_s;
    logic [7:0] p1_health_next_s;
    logic [7:0] p2_health_next_s;

    // Range check, land detection and post-hit health values.
    always_comb begin
        dist_s           = 10'd0;
        in_range_s       = 1'b0;
        p1_land_s        = 1'b0;
        p2_land_s        = 1'b0;
        p1_health_next_s = p1_health_r;
        p2_health_next_s = p2_health_r;
        if (bus.p1_x >= bus.p2_x) begin
            dist_s = bus.p1_x - bus.p2_x;
        end else begin
            dist_s = bus.p2_x - bus.p1_x;
        end
        in_range_s = (dist_s <= REACH);
        if (bus.frame_tick && (state_r == FIGHT) && in_range_s) begin
            p1_land_s = bus.p1_punch && !p1_landed_r;
            p2_land_s = bus.p2_punch && !p2_landed_r;
        end else begin
            p1_land_s = 1'b0;
            p2_land_s = 1'b0;
        end
        if (p2_land_s) begin
            p1_health_next_s = sat_sub(p1_health_r, DAMAGE);
        end else begin
            p1_health_next_s = p1_health_r;
        end
        if (p1_land_s) begin
            p2_health_next_s = sat_sub(p2_health_r, DAMAGE);
        end else begin
            p2_health_next_s = p2_health_r;
        end
    end

    // Round FSM with registered hit, health and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= FIGHT;
            cnt_r        <= 4'd0;
            p1_landed_r  <= 1'b0;
            p2_landed_r  <= 1'b0;
            p1_hit_r     <= 1'b0;
            p2_hit_r     <= 1'b0;
            p1_health_r  <= MAX_HEALTH;
            p2_health_r  <= MAX_HEALTH;
            round_over_r <= 1'b0;
            winner_r     <= 2'b00;
        end else begin
            // A hit on player 2 comes from a player-1 land and vice versa.
            p2_hit_r <= p1_land_s;
            p1_hit_r <= p2_land_s;

            if (!bus.p1_punch) begin
                p1_landed_r <= 1'b0;
            end else if (p1_land_s) begin
                p1_landed_r <= 1'b1;
            end
            if (!bus.p2_punch) begin
                p2_landed_r <= 1'b0;
            end else if (p2_land_s) begin
                p2_landed_r <= 1'b1;
            end

            if (bus.frame_tick) begin
                case (state_r)
                    FIGHT: begin
                        if (p1_land_s || p2_land_s) begin
                            p1_health_r <= p1_health_next_s;
                            p2_health_r <= p2_health_next_s;
                            if ((p1_health_next_s == 8'd0) || (p2_health_next_s == 8'd0)) begin
                                state_r      <= KO;
                                round_over_r <= 1'b1;
                                winner_r     <= {p1_health_next_s == 8'd0, p2_health_next_s == 8'd0};
                            end else begin
                                state_r <= HITSTOP;
                                cnt_r   <= HITSTOP_LOAD;
                            end
                        end
                    end
                    HITSTOP: begin
                        if (cnt_r <= 4'd1) begin
                            state_r <= FIGHT;
                            cnt_r   <= 4'd0;
                        end else begin
                            cnt_r <= cnt_r - 4'd1;
                        end
                    end
                    KO: begin
                        if (bus.restart) begin
                            state_r      <= FIGHT;
                            p1_health_r  <= MAX_HEALTH;
                            p2_health_r  <= MAX_HEALTH;
                            round_over_r <= 1'b0;
                            winner_r     <= 2'b00;
                            p1_landed_r  <= 1'b0;
                            p2_landed_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= FIGHT;
                        cnt_r   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.p1_hit     = p1_hit_r;
    assign bus.p2_hit     = p2_hit_r;
    assign bus.p1_health  = p1_health_r;
    assign bus.p2_health  = p2_health_r;
    assign bus.round_over = round_over_r;
    assign bus.winner     = winner_r;

endmodule

// File: tb/tb_fight_arbiter.sv
// Directed bench for fight_arbiter: a default instance plus a low-health,
// zero-hitstop instance used for saturation, KO, restart and double KO.
module tb_fight_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       p1_punch = 1'b0;
    logic       p2_punch = 1'b0;
    logic [9:0] p1_x = 10'd100;
    logic [9:0] p2_x = 10'd140;
    logic       restart = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int hits_a;
    int hits_b;

    always #5 clk = ~clk;

    fight_arbiter_if ifa ();
    fight_arbiter_if ifb ();

    assign ifa.frame_tick = frame_tick;
    assign ifa.p1_punch   = p1_punch;
    assign ifa.p2_punch   = p2_punch;
    assign ifa.p1_x       = p1_x;
    assign ifa.p2_x       = p2_x;
    assign ifa.restart    = restart;
    assign ifb.frame_tick = frame_tick;
    assign ifb.p1_punch   = p1_punch;
    assign ifb.p2_punch   = p2_punch;
    assign ifb.p1_x       = p1_x;
    assign ifb.p2_x       = p2_x;
    assign ifb.restart    = restart;

    fight_arbiter dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    fight_arbiter #(
        .MAX_HEALTH     (8'd25),
        .HITSTOP_FRAMES (4'd0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame tick; on return the registered results of that tick are visible.
    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    // Release currently held punches for one non-tick cycle, then press again.
    task automatic press_again();
        logic s1;
        logic s2;
        s1 = p1_punch;
        s2 = p2_punch;
        @(negedge clk);
        p1_punch = 1'b0;
        p2_punch = 1'b0;
        @(negedge clk);
        p1_punch = s1;
        p2_punch = s2;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_p1_health", ifa.p1_health, 8'd100);
        check_val("rst_p2_health", ifa.p2_health, 8'd100);
        check_val("rst_hits", {ifa.p1_hit, ifa.p2_hit}, 2'b00);
        check_val("rst_round_over", ifa.round_over, 1'b0);
        check_val("rst_winner", ifa.winner, 2'b00);
        @(negedge clk) rst_n = 1'b1;

        // Held punch lands exactly once over 10 ticks
        p1_x = 10'd100;
        p2_x = 10'd140;
        p1_punch = 1'b1;
        hits_a = 0;
        hits_b = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            hits_a += int'(ifa.p2_hit);
            hits_b += int'(ifa.p1_hit);
        end
        check_val("held_p2_hits", hits_a, 1);
        check_val("held_p1_hits", hits_b, 0);
        check_val("held_p2_health", ifa.p2_health, 8'd90);
        check_val("held_p1_health", ifa.p1_health, 8'd100);

        // New press after hitstop lands again
        press_again();
        do_tick();
        check_val("repress_hit", ifa.p2_hit, 1'b1);
        check_val("repress_health", ifa.p2_health, 8'd80);

        // Reset mid-hitstop, with a tick in the reset cycle
        do_tick();
        do_tick();
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        frame_tick = 1'b0;
        check_val("midrst_p2_health", ifa.p2_health, 8'd100);
        check_val("midrst_hits", {ifa.p1_hit, ifa.p2_hit}, 2'b00);
        check_val("midrst_round_over", ifa.round_over, 1'b0);
        do_tick();
        check_val("postrst_hit", ifa.p2_hit, 1'b1);
        check_val("postrst_health", ifa.p2_health, 8'd90);
        p1_punch = 1'b0;
        for (int i = 0; i < 6; i++) do_tick();

        // Range boundary with p1 to the right of p2
        p1_x = 10'd300;
        p2_x = 10'd100;
        p2_punch = 1'b1;
        do_tick();
        check_val("dist200_hit", ifa.p1_hit, 1'b0);
        p2_x = 10'd251;
        do_tick();
        check_val("dist49_hit", ifa.p1_hit, 1'b0);
        p2_x = 10'd252;
        do_tick();
        check_val("dist48_hit", ifa.p1_hit, 1'b1);
        check_val("dist48_health", ifa.p1_health, 8'd90);
        p2_punch = 1'b0;

        // Trade and hitstop length
        do_reset();
        p1_x = 10'd100;
        p2_x = 10'd140;
        p1_punch = 1'b1;
        p2_punch = 1'b1;
        do_tick();
        check_val("trade_hits", {ifa.p1_hit, ifa.p2_hit}, 2'b11);
        check_val("trade_p1_health", ifa.p1_health, 8'd90);
        check_val("trade_p2_health", ifa.p2_health, 8'd90);
        press_again();
        hits_a = 0;
        for (int i = 0; i < 6; i++) begin
            do_tick();
            hits_a += int'(ifa.p1_hit) + int'(ifa.p2_hit);
        end
        check_val("hitstop_hits", hits_a, 0);
        do_tick();
        check_val("after_hitstop_hits", {ifa.p1_hit, ifa.p2_hit}, 2'b11);
        check_val("after_hitstop_health", ifa.p2_health, 8'd80);

        // Instance B: one-tick hitstop, saturation to 0 and KO
        do_reset();
        p2_punch = 1'b0;
        press_again();
        do_tick();
        check_val("b_hit1", ifb.p2_hit, 1'b1);
        check_val("b_health1", ifb.p2_health, 8'd15);
        press_again();
        do_tick();
        check_val("b_hs_exit_hit", ifb.p2_hit, 1'b0);
        do_tick();
        check_val("b_hit2", ifb.p2_hit, 1'b1);
        check_val("b_health2", ifb.p2_health, 8'd5);
        press_again();
        do_tick();
        do_tick();
        check_val("b_ko_hit", ifb.p2_hit, 1'b1);
        check_val("b_sat_health", ifb.p2_health, 8'd0);
        check_val("b_round_over", ifb.round_over, 1'b1);
        check_val("b_winner", ifb.winner, 2'b01);
        p2_punch = 1'b1;
        press_again();
        do_tick();
        check_val("b_ko_nohit", {ifb.p1_hit, ifb.p2_hit}, 2'b00);
        check_val("b_ko_p1_health", ifb.p1_health, 8'd25);
        do_tick();
        check_val("b_ko_hold", ifb.round_over, 1'b1);

        // Restart from KO
        restart = 1'b1;
        do_tick();
        restart = 1'b0;
        check_val("b_rs_round_over", ifb.round_over, 1'b0);
        check_val("b_rs_winner", ifb.winner, 2'b00);
        check_val("b_rs_p1_health", ifb.p1_health, 8'd25);
        check_val("b_rs_p2_health", ifb.p2_health, 8'd25);

        // Both held punches land after restart; repeated trades end in double KO
        do_tick();
        check_val("b_trade1", ifb.p1_health, 8'd15);
        press_again();
        do_tick();
        do_tick();
        check_val("b_trade2", ifb.p2_health, 8'd5);
        press_again();
        do_tick();
        do_tick();
        check_val("b_dko_hits", {ifb.p1_hit, ifb.p2_hit}, 2'b11);
        check_val("b_dko_winner", ifb.winner, 2'b11);
        check_val("b_dko_round_over", ifb.round_over, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
